signed_math_unit: RTL and testbench

Registered signed-arithmetic block: from one pair of two's-complement operands it produces a saturating sum, a full-precision product and a scaled, saturating product in parallel. It serves the fixed-point datapaths (effects, brightness and gain scaling), where wrap-around would cause visible artefacts. All results appear together one clock after the operands.

---
 rtl/signed_math_pkg.sv | 19 +
 rtl/signed_saturate.sv | 45 ++++
 rtl/signed_math_unit.sv | 127 ++++++++++++
 tb/tb_signed_math_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/signed_math_pkg.sv
// Shared helpers for the signed arithmetic block.
//   max_int  - larger of two widths (sizes the adder)
//   sat_max  - largest two's-complement value representable in 'width' bits
//   sat_min  - smallest two's-complement value representable in 'width' bits
package signed_math_pkg;

    function automatic int unsigned max_int(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

    function automatic logic signed [63:0] sat_max(input int unsigned width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/signed_saturate.sv
// Combinational narrowing clamp for two's-complement values.
// Ports:
//   din   in  IN_SIZE   signed value to narrow
//   dout  out OUT_SIZE  din clamped to the OUT_SIZE signed range
//   sat   out 1         dout differs from din (clamping occurred)
// When OUT_SIZE >= IN_SIZE the value always fits: dout is din sign-extended and sat is 0.
module signed_saturate
    import signed_math_pkg::*;
#(
    parameter int unsigned IN_SIZE  = 5,
    parameter int unsigned OUT_SIZE = 4
) (
    input  logic [IN_SIZE-1:0]  din,
    output logic [OUT_SIZE-1:0] dout,
    output logic                sat
);

    if (IN_SIZE > OUT_SIZE) begin : g_clamp
        localparam logic [OUT_SIZE-1:0] MaxVal = OUT_SIZE'(sat_max(OUT_SIZE));
        localparam logic [OUT_SIZE-1:0] MinVal = OUT_SIZE'(sat_min(OUT_SIZE));

        // The value fits exactly when every bit from the output sign position upward matches.
        logic [IN_SIZE-OUT_SIZE:0] upper;
        logic                      fits;

        assign upper = din[IN_SIZE-1:OUT_SIZE-1];
        assign fits  = (upper == '0) || (upper == '1);

        always_comb begin
            dout = din[OUT_SIZE-1:0];
            sat  = 1'b0;
            if (!fits) begin
                sat  = 1'b1;
                dout = din[IN_SIZE-1] ? MinVal : MaxVal;
            end
        end
    end else if (IN_SIZE == OUT_SIZE) begin : g_pass
        assign dout = din;
        assign sat  = 1'b0;
    end else begin : g_extend
        assign dout = {{(OUT_SIZE - IN_SIZE){din[IN_SIZE-1]}}, din};
        assign sat  = 1'b0;
    end

endmodule

// File: rtl/signed_math_unit.sv
// Registered signed arithmetic: saturating sum, exact product and scaled saturating
// product of one operand pair, all presented together one clock after the operands.
// Ports:
//   clk          in  1         rising-edge clock
//   rst          in  1         asynchronous active-high reset, clears all outputs
//   in_valid     in  1         operands valid; output registers load only when high
//   a            in  A_SIZE    signed operand
//   b            in  B_SIZE    signed operand
//   out_valid    out 1         in_valid delayed by one cycle
//   add_out      out S         a+b clamped to S bits
//   add_sat      out 1         add_out was clamped
//   mul_out      out P         exact a*b
//   sat_mul_out  out OUT_SIZE  (a*b)>>>OFFSET clamped to OUT_SIZE bits
//   mul_sat      out 1         sat_mul_out was clamped
module signed_math_unit
    import signed_math_pkg::*;
#(
    parameter int unsigned A_SIZE   = 4,
    parameter int unsigned B_SIZE   = 4,
    parameter int unsigned OFFSET   = 0,
    parameter int unsigned OUT_SIZE = 4,
    localparam int unsigned S = max_int(A_SIZE, B_SIZE),
    localparam int unsigned P = A_SIZE + B_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [A_SIZE-1:0]   a,
    input  logic [B_SIZE-1:0]   b,
    output logic                out_valid,
    output logic [S-1:0]        add_out,
    output logic                add_sat,
    output logic [P-1:0]        mul_out,
    output logic [OUT_SIZE-1:0] sat_mul_out,
    output logic                mul_sat
);

    localparam int unsigned Q = P - OFFSET;

    // Adder: one guard bit above S so the sum itself can never wrap.
    logic [S:0] a_add;
    logic [S:0] b_add;
    logic [S:0] sum;

    assign a_add = {{(S + 1 - A_SIZE){a[A_SIZE-1]}}, a};
    assign b_add = {{(S + 1 - B_SIZE){b[B_SIZE-1]}}, b};
    assign sum   = a_add + b_add;

    // Multiplier: the low P bits of the product of P-bit sign-extended operands are
    // the exact signed product, including (-2^(A-1))*(-2^(B-1)).
    logic [P-1:0] a_mul;
    logic [P-1:0] b_mul;
    logic [P-1:0] prod;

    assign a_mul = {{B_SIZE{a[A_SIZE-1]}}, a};
    assign b_mul = {{A_SIZE{b[B_SIZE-1]}}, b};
    assign prod  = a_mul * b_mul;

    // Dropping the low OFFSET bits is an arithmetic shift rounding toward -inf;
    // keeping Q bits loses nothing, so the clamp sees the true shifted value.
    logic [Q-1:0] shifted;

    assign shifted = prod[P-1:OFFSET];

    logic [S-1:0]        add_d;
    logic                add_sat_d;
    logic [OUT_SIZE-1:0] sat_mul_d;
    logic                mul_sat_d;

    signed_saturate #(
        .IN_SIZE  (S + 1),
        .OUT_SIZE (S)
    ) u_add_sat (
        .din  (sum),
        .dout (add_d),
        .sat  (add_sat_d)
    );

    signed_saturate #(
        .IN_SIZE  (Q),
        .OUT_SIZE (OUT_SIZE)
    ) u_mul_sat (
        .din  (shifted),
        .dout (sat_mul_d),
        .sat  (mul_sat_d)
    );

    logic                out_valid_q;
    logic [S-1:0]        add_q;
    logic                add_sat_q;
    logic [P-1:0]        mul_q;
    logic [OUT_SIZE-1:0] sat_mul_q;
    logic                mul_sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
        end
    end

    // Results hold their last value while in_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_q     <= '0;
            add_sat_q <= 1'b0;
            mul_q     <= '0;
            sat_mul_q <= '0;
            mul_sat_q <= 1'b0;
        end else if (in_valid) begin
            add_q     <= add_d;
            add_sat_q <= add_sat_d;
            mul_q     <= prod;
            sat_mul_q <= sat_mul_d;
            mul_sat_q <= mul_sat_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign add_out     = add_q;
    assign add_sat     = add_sat_q;
    assign mul_out     = mul_q;
    assign sat_mul_out = sat_mul_q;
    assign mul_sat     = mul_sat_q;

endmodule

// File: tb/tb_signed_math_unit.sv
// Bench for signed_math_unit: three instances (4/4/0/4, 4/4/2/4, 8/4/0/8) driven in
// lock-step and compared against an integer reference model of the arithmetic rules.
module tb_signed_math_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;

    logic [3:0] a0 = '0;
    logic [3:0] b0 = '0;
    logic [7:0] a2 = '0;
    logic [3:0] b2 = '0;

    logic       ov0, as0, ms0;
    logic [3:0] add0, sm0;
    logic [7:0] mul0;

    logic       ov1, as1, ms1;
    logic [3:0] add1, sm1;
    logic [7:0] mul1;

    logic        ov2, as2, ms2;
    logic [7:0]  add2, sm2;
    logic [11:0] mul2;

    int total = 0;
    int bad = 0;

    // Operands most recently loaded (zero after reset, which models the cleared outputs).
    int la0 = 0, lb0 = 0, la2 = 0, lb2 = 0;

    always #5 clk = ~clk;

    signed_math_unit #(.A_SIZE(4), .B_SIZE(4), .OFFSET(0), .OUT_SIZE(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a0), .b(b0),
        .out_valid(ov0), .add_out(add0), .add_sat(as0), .mul_out(mul0),
        .sat_mul_out(sm0), .mul_sat(ms0)
    );

    signed_math_unit #(.A_SIZE(4), .B_SIZE(4), .OFFSET(2), .OUT_SIZE(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a0), .b(b0),
        .out_valid(ov1), .add_out(add1), .add_sat(as1), .mul_out(mul1),
        .sat_mul_out(sm1), .mul_sat(ms1)
    );

    signed_math_unit #(.A_SIZE(8), .B_SIZE(4), .OFFSET(0), .OUT_SIZE(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a2), .b(b2),
        .out_valid(ov2), .add_out(add2), .add_sat(as2), .mul_out(mul2),
        .sat_mul_out(sm2), .mul_sat(ms2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic with explicit clamping.
    task automatic model(input int a, input int b, input int asz, input int bsz,
                         input int off, input int osz,
                         output int add, output int asat, output int mul,
                         output int smul, output int msat);
        int s, hi, lo;
        s = (asz > bsz) ? asz : bsz;
        hi = (1 << (s - 1)) - 1;
        lo = -(1 << (s - 1));
        add = a + b;
        asat = 0;
        if (add > hi) begin add = hi; asat = 1; end
        else if (add < lo) begin add = lo; asat = 1; end
        mul = a * b;
        smul = mul >>> off;
        hi = (1 << (osz - 1)) - 1;
        lo = -(1 << (osz - 1));
        msat = 0;
        if (smul > hi) begin smul = hi; msat = 1; end
        else if (smul < lo) begin smul = lo; msat = 1; end
    endtask

    task automatic check_all(input int ev);
        int e_add, e_as, e_mul, e_sm, e_ms;
        model(la0, lb0, 4, 4, 0, 4, e_add, e_as, e_mul, e_sm, e_ms);
        check("d0.valid", int'(ov0), ev);
        check("d0.add", int'($signed(add0)), e_add);
        check("d0.add_sat", int'(as0), e_as);
        check("d0.mul", int'($signed(mul0)), e_mul);
        check("d0.sat_mul", int'($signed(sm0)), e_sm);
        check("d0.mul_sat", int'(ms0), e_ms);
        model(la0, lb0, 4, 4, 2, 4, e_add, e_as, e_mul, e_sm, e_ms);
        check("d1.valid", int'(ov1), ev);
        check("d1.add", int'($signed(add1)), e_add);
        check("d1.mul", int'($signed(mul1)), e_mul);
        check("d1.sat_mul", int'($signed(sm1)), e_sm);
        check("d1.mul_sat", int'(ms1), e_ms);
        model(la2, lb2, 8, 4, 0, 8, e_add, e_as, e_mul, e_sm, e_ms);
        check("d2.valid", int'(ov2), ev);
        check("d2.add", int'($signed(add2)), e_add);
        check("d2.add_sat", int'(as2), e_as);
        check("d2.mul", int'($signed(mul2)), e_mul);
        check("d2.sat_mul", int'($signed(sm2)), e_sm);
        check("d2.mul_sat", int'(ms2), e_ms);
    endtask

    // One valid operand set, checked one clock later.
    task automatic step(input int va0, input int vb0, input int va2, input int vb2);
        @(negedge clk);
        a0 = 4'(va0);
        b0 = 4'(vb0);
        a2 = 8'(va2);
        b2 = 4'(vb2);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        la0 = va0; lb0 = vb0; la2 = va2; lb2 = vb2;
        check_all(1);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_all(0);
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive 4-bit sweep, in_valid held high; random operands on the wide instance.
        for (int i = -8; i < 8; i++) begin
            for (int j = -8; j < 8; j++) begin
                step(i, j, int'($signed(8'($urandom))), int'($signed(4'($urandom))));
            end
        end

        // Random operands with random in_valid gaps.
        for (int n = 0; n < 200; n++) begin
            int ra0, rb0, ra2, rb2, iv;
            ra0 = int'($signed(4'($urandom)));
            rb0 = int'($signed(4'($urandom)));
            ra2 = int'($signed(8'($urandom)));
            rb2 = int'($signed(4'($urandom)));
            iv = int'($urandom_range(0, 3) != 0);
            @(negedge clk);
            a0 = 4'(ra0); b0 = 4'(rb0); a2 = 8'(ra2); b2 = 4'(rb2);
            in_valid = iv[0];
            @(posedge clk);
            #1;
            if (iv != 0) begin
                la0 = ra0; lb0 = rb0; la2 = ra2; lb2 = rb2;
            end
            check_all(iv);
        end

        // Directed corners with values worked out by hand.
        step(7, 7, -128, -8);
        check("c77.add", int'($signed(add0)), 7);
        check("c77.add_sat", int'(as0), 1);
        check("c77.mul", int'($signed(mul0)), 49);
        check("c77.sat_mul", int'($signed(sm0)), 7);
        check("c77.mul_sat", int'(ms0), 1);
        check("w.mul", int'($signed(mul2)), 1024);
        check("w.add", int'($signed(add2)), -128);
        check("w.add_sat", int'(as2), 1);
        check("w.sat_mul", int'($signed(sm2)), 127);

        step(-8, -8, 0, 0);
        check("c88.add", int'($signed(add0)), -8);
        check("c88.add_sat", int'(as0), 1);
        check("c88.mul", int'($signed(mul0)), 64);
        check("c88.sat_mul", int'($signed(sm0)), 7);
        check("off2.c88.sat_mul", int'($signed(sm1)), 7);
        check("off2.c88.mul_sat", int'(ms1), 1);

        step(-8, -1, 0, 0);
        check("c81.add", int'($signed(add0)), -8);
        check("c81.mul", int'($signed(mul0)), 8);
        check("c81.sat_mul", int'($signed(sm0)), 7);

        step(-8, 7, 0, 0);
        check("c87.add", int'($signed(add0)), -1);
        check("c87.add_sat", int'(as0), 0);
        check("c87.mul", int'($signed(mul0)), -56);
        check("c87.sat_mul", int'($signed(sm0)), -8);
        check("c87.mul_sat", int'(ms0), 1);

        step(7, 3, 0, 0);
        check("off2.c73.sat_mul", int'($signed(sm1)), 5);
        step(-7, 3, 0, 0);
        check("off2.cm73.sat_mul", int'($signed(sm1)), -6);

        // Reset asserted between edges while streaming: outputs clear without a clock.
        step(3, -2, 100, 5);
        check("c32.add", int'($signed(add0)), 1);
        check("c32.mul", int'($signed(mul0)), -6);
        check("c32.sat_mul", int'($signed(sm0)), -6);
        @(negedge clk);
        a0 = 4'(5); b0 = 4'(5); a2 = 8'(77); b2 = 4'(3);
        #2;
        rst = 1'b1;
        #1;
        la0 = 0; lb0 = 0; la2 = 0; lb2 = 0;
        check_all(0);
        @(posedge clk);
        #1;
        check_all(0);
        @(negedge clk);
        rst = 1'b0;

        // Hold: results stay put for three idle cycles.
        step(3, -2, -50, 7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a0 = 4'($urandom); b0 = 4'($urandom); a2 = 8'($urandom); b2 = 4'($urandom);
            @(posedge clk);
            #1;
            check_all(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
